// File: rtl/vram_arbiter.sv
// vram_arbiter: lets the CRTC character fetch and the Z80 share one single-port
// video RAM. Every access takes two cycles on the RAM port (ADDR, DATA).
// Video has priority, except that a CPU request waiting at the end of a video
// access is served next, so the CPU is never starved.
module vram_arbiter #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    // video fetch side
    input  logic          vreq,
    input  logic [AW-1:0] va,
    output logic [DW-1:0] vq,
    output logic          vvalid,
    // CPU side
    input  logic          creq,
    input  logic          cwr,
    input  logic [AW-1:0] ca,
    input  logic [DW-1:0] cd,
    output logic [DW-1:0] cq,
    output logic          cack,
    output logic          overrun,
    // RAM side
    output logic [AW-1:0] ram_a,
    output logic          ram_we,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_q
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VADDR = 3'd1,
        VDATA = 3'd2,
        CADDR = 3'd3,
        CDATA = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            vpend_q, vpend_d;
    logic [AW-1:0]   va_q, va_d;
    logic            cbusy_q, cbusy_d;
    logic            cwr_q, cwr_d;
    logic            overrun_q, overrun_d;
    logic            vvalid_q, vvalid_d;
    logic            cack_q, cack_d;
    logic [DW-1:0]   vq_q, vq_d;
    logic [DW-1:0]   cq_q, cq_d;
    logic [AW-1:0]   ram_a_q, ram_a_d;
    logic            ram_we_q, ram_we_d;
    logic [DW-1:0]   ram_d_q, ram_d_d;

    logic decide, vid_elig, cpu_elig, grant_v, grant_c;

    // Arbitration: decisions happen only when the port is free (IDLE) or in
    // the last cycle of an access. A CPU waiting behind a video access wins.
    always_comb begin
        decide   = (state_q == IDLE) || (state_q == VDATA) || (state_q == CDATA);
        vid_elig = vreq || vpend_q;
        cpu_elig = creq && !cbusy_q;
        grant_v  = decide && vid_elig && !((state_q == VDATA) && cpu_elig);
        grant_c  = decide && !grant_v && cpu_elig;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        vpend_d   = vpend_q;
        va_d      = va_q;
        cbusy_d   = cbusy_q;
        cwr_d     = cwr_q;
        overrun_d = overrun_q;
        vvalid_d  = 1'b0;
        cack_d    = 1'b0;
        vq_d      = vq_q;
        cq_d      = cq_q;
        ram_a_d   = ram_a_q;
        ram_we_d  = 1'b0;
        ram_d_d   = ram_d_q;

        // A new vreq always replaces any unserved pending address.
        if (vreq) va_d = va;
        if (grant_v)   vpend_d = 1'b0;
        else if (vreq) vpend_d = 1'b1;
        if (vreq && vpend_q && !grant_v) overrun_d = 1'b1;

        // cbusy blocks re-grant until the CPU has dropped creq at least once.
        if (grant_c)   cbusy_d = 1'b1;
        else if (!creq) cbusy_d = 1'b0;

        // Data returns one cycle after the DATA phase (synchronous RAM read).
        if (state_q == VDATA) begin
            vvalid_d = 1'b1;
            vq_d     = ram_q;
        end
        if (state_q == CDATA) begin
            cack_d = 1'b1;
            if (!cwr_q) cq_d = ram_q;
        end

        unique case (state_q)
            VADDR:   state_d = VDATA;
            CADDR:   state_d = CDATA;
            default: state_d = IDLE;
        endcase

        if (grant_v) begin
            state_d = VADDR;
            ram_a_d = vreq ? va : va_q;
        end else if (grant_c) begin
            state_d  = CADDR;
            ram_a_d  = ca;
            ram_d_d  = cd;
            ram_we_d = cwr;
            cwr_d    = cwr;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            vpend_q   <= 1'b0;
            va_q      <= '0;
            cbusy_q   <= 1'b0;
            cwr_q     <= 1'b0;
            overrun_q <= 1'b0;
            vvalid_q  <= 1'b0;
            cack_q    <= 1'b0;
            vq_q      <= '0;
            cq_q      <= '0;
            ram_a_q   <= '0;
            ram_we_q  <= 1'b0;
            ram_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            vpend_q   <= vpend_d;
            va_q      <= va_d;
            cbusy_q   <= cbusy_d;
            cwr_q     <= cwr_d;
            overrun_q <= overrun_d;
            vvalid_q  <= vvalid_d;
            cack_q    <= cack_d;
            vq_q      <= vq_d;
            cq_q      <= cq_d;
            ram_a_q   <= ram_a_d;
            ram_we_q  <= ram_we_d;
            ram_d_q   <= ram_d_d;
        end
    end

    assign vq      = vq_q;
    assign vvalid  = vvalid_q;
    assign cq      = cq_q;
    assign cack    = cack_q;
    assign overrun = overrun_q;
    assign ram_a   = ram_a_q;
    assign ram_we  = ram_we_q;
    assign ram_d   = ram_d_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: synchronous RAM model, a slot-level model of the
// arbitration compared every cycle, and directed scenarios with literal checks.
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        vreq;
    logic [13:0] va;
    logic [7:0]  vq;
    logic        vvalid;
    logic        creq, cwr;
    logic [13:0] ca;
    logic [7:0]  cd;
    logic [7:0]  cq;
    logic        cack, overrun;
    logic [13:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;

    int checks = 0;
    int fails  = 0;
    logic chk_en = 1'b0;

    vram_arbiter #(.AW(14), .DW(8)) dut (
        .clock(clock), .reset(reset),
        .vreq(vreq), .va(va), .vq(vq), .vvalid(vvalid),
        .creq(creq), .cwr(cwr), .ca(ca), .cd(cd), .cq(cq), .cack(cack),
        .overrun(overrun),
        .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            16'h0123: return 8'h5A;
            16'h0455: return 8'h11;
            16'h0456: return 8'hC3;
            default:  return 8'(i) ^ 8'h3C;
        endcase
    endfunction

    // Synchronous single-port RAM, read-before-write.
    logic [7:0] ram [0:16383];
    bit ram_init = 1'b0;
    always @(posedge clock) begin
        if (!ram_init) begin
            for (int i = 0; i < 16384; i++) ram[i] = init_byte(i);
            ram_init = 1'b1;
        end
        ram_q <= ram[ram_a];
        if (ram_we) ram[ram_a] = ram_d;
    end

    // Slot model: the port is owned by one requester for an ADDR and a DATA
    // slot; ownership is re-decided when free or on the DATA slot.
    logic [7:0]  mmem [0:16383];
    bit          m_init = 1'b0;
    int          m_own = 0;   // 0 none, 1 video, 2 cpu
    int          m_ph  = 0;   // 1 address slot, 2 data slot
    logic        m_vp = 0, m_cb = 0, m_wr = 0;
    logic [13:0] m_va = '0, m_addr = '0;
    logic        e_vvalid = 0, e_cack = 0, e_we = 0, e_ovr = 0;
    logic [13:0] e_a = '0;
    logic [7:0]  e_d = '0, e_vq = '0, e_cq = '0;

    always @(posedge clock) begin
        logic free, cpu_ok, vid_ok, gv, gc, done_v, done_c;
        if (!m_init) begin
            for (int i = 0; i < 16384; i++) mmem[i] = init_byte(i);
            m_init = 1'b1;
        end
        if (reset) begin
            m_own = 0; m_ph = 0; m_vp = 0; m_cb = 0; m_wr = 0;
            e_vvalid = 0; e_cack = 0; e_we = 0; e_ovr = 0;
            e_a = '0; e_d = '0; e_vq = '0; e_cq = '0;
        end else begin
            done_v = (m_own == 1) && (m_ph == 2);
            done_c = (m_own == 2) && (m_ph == 2);
            free   = (m_own == 0) || (m_ph == 2);
            cpu_ok = creq && !m_cb;
            vid_ok = vreq || m_vp;
            gv = free && vid_ok && !(done_v && cpu_ok);
            gc = free && !gv && cpu_ok;

            e_vvalid = done_v;
            e_cack   = done_c;
            if (done_v) e_vq = mmem[m_addr];
            if (done_c && !m_wr) e_cq = mmem[m_addr];

            if (vreq && m_vp && !gv) e_ovr = 1'b1;
            e_we = gc && cwr;
            if (gv) begin
                m_addr = vreq ? va : m_va;
                e_a = m_addr; m_own = 1; m_ph = 1;
            end else if (gc) begin
                m_addr = ca; m_wr = cwr; e_a = ca; e_d = cd; m_own = 2; m_ph = 1;
                if (cwr) mmem[ca] = cd;
            end else if (free) begin
                m_own = 0; m_ph = 0;
            end else begin
                m_ph = 2;
            end
            if (gv) m_vp = 1'b0; else if (vreq) m_vp = 1'b1;
            if (vreq) m_va = va;
            if (gc) m_cb = 1'b1; else if (!creq) m_cb = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("vvalid",  vvalid,  e_vvalid);
            chk("cack",    cack,    e_cack);
            chk("ram_we",  ram_we,  e_we);
            chk("ram_a",   ram_a,   e_a);
            chk("ram_d",   ram_d,   e_d);
            chk("overrun", overrun, e_ovr);
            chk("vq",      vq,      e_vq);
            chk("cq",      cq,      e_cq);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int nvreq, nvv, rise;
        reset = 1; vreq = 0; va = '0; creq = 0; cwr = 0; ca = '0; cd = '0;
        tick; tick;
        chk_en = 1'b1;
        chk("rst_vvalid", vvalid, 0);
        chk("rst_cack", cack, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_overrun", overrun, 0);
        reset = 0;
        tick;

        // Video only
        vreq = 1; va = 14'h0123;
        tick; vreq = 0;
        chk("v_ram_a_c1", ram_a, 14'h0123);
        chk("v_we_c1", ram_we, 0);
        tick;
        chk("v_vvalid_c2", vvalid, 0);
        tick;
        chk("v_vvalid_c3", vvalid, 1);
        chk("v_vq_c3", vq, 8'h5A);
        chk("v_overrun", overrun, 0);
        tick; tick;

        // CPU write then read of the top address
        creq = 1; cwr = 1; ca = 14'h3FFF; cd = 8'hA5;
        tick;
        chk("w_we_c1", ram_we, 1);
        chk("w_a_c1", ram_a, 14'h3FFF);
        chk("w_d_c1", ram_d, 8'hA5);
        tick;
        chk("w_we_c2", ram_we, 0);
        tick;
        chk("w_cack_c3", cack, 1);
        creq = 0;
        tick; tick;
        creq = 1; cwr = 0; ca = 14'h3FFF; cd = 8'h00;
        tick;
        chk("r_we_c1", ram_we, 0);
        tick; tick;
        chk("r_cack_c3", cack, 1);
        chk("r_cq_c3", cq, 8'hA5);
        creq = 0;
        tick; tick;

        // Collision from IDLE: video first, then CPU
        vreq = 1; va = 14'h0123; creq = 1; cwr = 0; ca = 14'h0456;
        tick; vreq = 0;
        chk("col_ram_a_c1", ram_a, 14'h0123);
        tick; tick;
        chk("col_vvalid_c3", vvalid, 1);
        chk("col_vq_c3", vq, 8'h5A);
        chk("col_caddr_c3", ram_a, 14'h0456);
        tick;
        chk("col_cack_c4", cack, 0);
        tick;
        chk("col_cack_c5", cack, 1);
        chk("col_cq_c5", cq, 8'hC3);
        creq = 0;
        tick; tick;

        // Fairness: vreq every 5 cycles, CPU re-requests right after each ack
        nvreq = 0; nvv = 0; rise = 0;
        for (int t = 0; t < 80; t++) begin
            if (vvalid) nvv++;
            if (creq) begin
                if (cack) begin
                    chk("fair_lat_le5", (t - rise) <= 5, 1);
                    creq = 0;
                end else if (t - rise >= 5) begin
                    chk("fair_ack_by5", cack, 1);
                    creq = 0;
                end
            end else begin
                creq = 1; rise = t; cwr = (t % 2) == 1;
                ca = 14'h1000 + 14'(t); cd = 8'(t) ^ 8'h96;
            end
            vreq = (t % 5 == 0) && (t < 70);
            if (vreq) begin
                nvreq++;
                va = 14'h2000 + 14'(t);
            end
            tick;
        end
        creq = 0; vreq = 0;
        tick; tick;
        chk("fair_no_lost_vreq", nvv, nvreq);
        chk("fair_overrun", overrun, 0);
        tick; tick;

        // Overrun: second and third vreq arrive before video is re-granted
        vreq = 1; va = 14'h0200; creq = 1; cwr = 0; ca = 14'h0300;
        tick; vreq = 0;                      // a+1 VADDR
        tick; vreq = 1; va = 14'h0455;       // a+2 VDATA, CPU wins next
        tick;                                // a+3 CADDR
        chk("ovr_first_vvalid", vvalid, 1);
        vreq = 1; va = 14'h0456;
        tick; vreq = 0;                      // a+4
        chk("ovr_set", overrun, 1);
        nvv = 0;
        for (int k = 4; k < 10; k++) begin
            if (vvalid) begin
                nvv++;
                chk("ovr_vq", vq, 8'hC3);
                chk("ovr_vcyc", k, 7);
            end
            if (cack) creq = 0;
            tick;
        end
        chk("ovr_one_vvalid", nvv, 1);
        chk("ovr_sticky", overrun, 1);

        // Reset in the middle of a write
        creq = 1; cwr = 1; ca = 14'h0010; cd = 8'h77;
        tick;
        chk("rw_we_c1", ram_we, 1);
        reset = 1;
        tick;
        chk("rw_we_after", ram_we, 0);
        chk("rw_cack_after", cack, 0);
        chk("rw_overrun_after", overrun, 0);
        chk("rw_ram_a_after", ram_a, 0);
        chk("rw_vq_after", vq, 0);
        chk("rw_cq_after", cq, 0);
        reset = 0; creq = 0;
        tick;
        chk("rw_cack_c3", cack, 0);
        creq = 1; cwr = 0; ca = 14'h0123;
        tick; tick; tick;
        chk("rw_read_cack", cack, 1);
        chk("rw_read_cq", cq, 8'h5A);
        creq = 0;
        tick; tick;

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port 16 KB video RAM between the CRTC character fetch and Z80 CPU accesses, replacing the dual-port RAM model for targets where only single-port block RAM or external SRAM is available. Video fetch has priority, with a fairness rule so the CPU is never starved. The block registers all RAM-side controls and returns data to each requester with a one-cycle valid/ack pulse. It sits between the CRTC/CPU glue and the physical RAM, inside the memory subsystem.

## Interface
Parameters:
- AW, 14, RAM address width (16 KB).
- DW, 8, data width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- vreq  in  1  video fetch request, one-cycle pulse per character.
- va  in  AW  video address, sampled when vreq=1.
- vq  out  DW  video read data, valid while vvalid=1, held afterwards.
- vvalid  out  1  one-cycle pulse: vq updated.
- creq  in  1  CPU request level (mreq active and address in RAM window), held until cack.
- cwr  in  1  1=write, 0=read; sampled at grant.
- ca  in  AW  CPU address; sampled at grant.
- cd  in  DW  CPU write data; sampled at grant.
- cq  out  DW  CPU read data, valid while cack=1 on reads, held afterwards.
- cack  out  1  one-cycle pulse: CPU access complete.
- overrun  out  1  sticky: a vreq arrived while one was already pending.
- ram_a  out  AW  registered RAM address.
- ram_we  out  1  registered write enable, active high.
- ram_d  out  DW  registered write data.
- ram_q  in  DW  RAM read data, synchronous, valid the cycle after ram_a is presented.

## Operation
- States: IDLE, VADDR, VDATA, CADDR, CDATA.
- vpend: set by vreq, latching va. Cleared on entry to VADDR.
- cbusy: set on entry to CADDR. Cleared when creq=0.
- CPU is eligible when creq=1 and cbusy=0.
- Grant decision is made in IDLE, VDATA and CDATA:
  - Video eligible (vreq or vpend) and not (current state VDATA and CPU eligible) -> VADDR.
  - Otherwise, CPU eligible -> CADDR.
  - Otherwise -> IDLE.
- VADDR: ram_a=latched va, ram_we=0. Always -> VDATA.
- CADDR: ram_a=ca, ram_d=cd, ram_we=cwr (all latched at grant). Always -> CDATA.
- ram_we is 1 only during CADDR of a write.
- Cycle after VDATA: vq<=ram_q, vvalid=1.
- Cycle after CDATA: cack=1. On reads cq<=ram_q; on writes cq is unchanged.
- Simultaneous vreq and CPU eligible from IDLE or CDATA: video wins.
- vreq while vpend=1 and not being granted that cycle: overrun<=1, new va overwrites old.
- vreq during VADDR/VDATA of a previous fetch is legal and sets vpend.
- Reset: state IDLE; vpend, cbusy, overrun, vvalid, cack, ram_we = 0; ram_a, ram_d, vq, cq = 0.
- Reset mid-access aborts the access: no vvalid/cack is issued, and ram_we is deasserted from the next cycle.

## Timing
- Port occupancy is 2 cycles per access (ADDR+DATA). Back-to-back grants are allowed, giving one access per 2 cycles.
- Video latency: vreq in cycle 0 from IDLE -> vvalid in cycle 3.
  - Worst case (vreq during VDATA with CPU eligible) -> vvalid in cycle 5.
- CPU latency: creq rising in cycle 0 from IDLE -> cack in cycle 3.
  - Worst case (vreq also present) -> cack in cycle 5.
- Integration requirement: vreq spacing ≥ 5 cycles. Spacing of 8 (one per vcep character) never sets overrun.
- creq must stay high until cack. Holding it high after cack causes no re-grant until creq has been low for ≥1 cycle.

## Test plan
- Video only: vreq with va=0x0123 and RAM[0x0123]=0x5A. Expect ram_a=0x0123 in cycle 1, vvalid in cycle 3 with vq=0x5A, overrun=0.
- CPU write then read: write 0xA5 to 0x3FFF (ram_we=1 for exactly one cycle, cack in cycle 3). Drop creq, then read 0x3FFF. Expect cq=0xA5 at cack.
- Collision: vreq and rising creq in the same cycle from IDLE. Expect VADDR first, vvalid in cycle 3, CADDR in cycle 3, cack in cycle 5.
- Fairness: vreq every 5 cycles while creq is held continuously and re-requested after each ack. Every CPU request is acked within 5 cycles, and no vreq is lost.
- Overrun: two vreq pulses 1 cycle apart while a CPU access is in CADDR. Expect overrun=1 (sticky), and exactly one vvalid returning the second va's data.
- Reset mid-write: assert reset during CADDR of a write. Expect ram_we=0 and cack=0 on the next cycle, all outputs at reset values, and a normal read afterwards.
